// File: rtl/uart_pkg.sv
// Shared definitions for the blackjack UART link (frame address map, flag bit
// positions, encoder FSM states). Used by both the encoder and the decoder.
package uart_pkg;

  localparam logic [3:0] FLAGS_ADDR     = 4'h0;
  localparam logic [3:0] CARD_ADDR_BASE = 4'h1;
  localparam int         NUM_CARDS      = 9;
  localparam int         NUM_ITEMS      = NUM_CARDS + 1;

  localparam int FLAG_FINISHED_BIT = 4;
  localparam int FLAG_DEAL_BIT     = 5;
  localparam int FLAG_START_BIT    = 6;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } enc_state_t;

endpackage

// File: rtl/uart_if.sv
// Card table bundle shared between game logic and the UART link encoder.
interface UART_if;
  import uart_pkg::*;

  logic [3:0] card_values [NUM_CARDS];

  modport in  (input  card_values);
  modport out (output card_values);

endinterface

// File: rtl/uart_dirty_picker.sv
// Lowest-set-bit encoder: selects the pending item with the smallest frame
// address so flags win over cards and cards go out in ascending order.
module uart_dirty_picker
  import uart_pkg::*;
(
  input  logic [NUM_ITEMS-1:0] dirty,
  output logic [3:0]           idx,
  output logic                 vld
);

  always_comb begin
    idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (dirty[i]) idx = 4'(i);
    end
  end

  assign vld = |dirty;

endmodule

// File: rtl/uart_encoder.sv
// Blackjack UART link encoder: sends one-byte frames for changed flags/cards.
// Optional periodic full resend is enabled by defining UART_ENCODER_REFRESH_EN.
module uart_encoder #(
  parameter int NUM_CARDS = 9
`ifdef UART_ENCODER_REFRESH_EN
  , parameter int REFRESH_CYCLES = 1_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       deal,
  input  logic       dealer_finished,
  UART_if.in         encoder_cards,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy
);
  import uart_pkg::*;

  localparam int ITEMS = NUM_CARDS + 1;

  enc_state_t       state, state_next;
  logic [3:0]       idx, idx_next;
  logic [7:0]       data_next;
  logic             wr_next;
  logic             commit;
  logic [2:0]       sent_flags;
  logic [3:0]       sent_cards [NUM_CARDS];
  logic [ITEMS-1:0] change, dirty;
  logic [3:0]       pick_idx, pick_card;
  logic             pick_vld;

  function automatic logic [7:0] flags_frame(input logic s, input logic d, input logic f);
    logic [7:0] b;
    b                    = '0;
    b[3:0]               = FLAGS_ADDR;
    b[FLAG_START_BIT]    = s;
    b[FLAG_DEAL_BIT]     = d;
    b[FLAG_FINISHED_BIT] = f;
    return b;
  endfunction

  always_comb begin
    change    = '0;
    change[0] = {start, deal, dealer_finished} != sent_flags;
    for (int i = 0; i < NUM_CARDS; i++) begin
      change[i+1] = encoder_cards.card_values[i] != sent_cards[i];
    end
  end

`ifdef UART_ENCODER_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_CYCLES);

  logic [CNT_W-1:0] refresh_cnt;
  logic [ITEMS-1:0] force_mask;

  // A wrap re-arms every item; a bit clears once its frame is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      force_mask  <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
      refresh_cnt <= '0;
      force_mask  <= '1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
      if (commit) force_mask <= force_mask & ~(ITEMS'(1) << idx);
    end
  end

  assign dirty = change | force_mask;
`else
  assign dirty = change;
`endif

  uart_dirty_picker u_picker (
    .dirty (dirty),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  always_comb begin
    pick_card = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (pick_idx == CARD_ADDR_BASE + 4'(i)) pick_card = encoder_cards.card_values[i];
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    data_next  = w_data;
    wr_next    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          idx_next   = pick_idx;
          data_next  = (pick_idx == FLAGS_ADDR) ? flags_frame(start, deal, dealer_finished)
                                                : {pick_card, pick_idx};
          state_next = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          wr_next    = 1'b1;
          commit     = 1'b1;
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      w_data  <= '0;
      wr_uart <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      w_data  <= data_next;
      wr_uart <= wr_next;
    end
  end

  // Shadows take the byte actually sent, so a mid-frame input change stays dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_flags <= '0;
      for (int i = 0; i < NUM_CARDS; i++) sent_cards[i] <= '0;
    end else if (commit) begin
      if (idx == FLAGS_ADDR)
        sent_flags <= {w_data[FLAG_START_BIT], w_data[FLAG_DEAL_BIT], w_data[FLAG_FINISHED_BIT]};
      for (int i = 0; i < NUM_CARDS; i++) begin
        if (idx == CARD_ADDR_BASE + 4'(i)) sent_cards[i] <= w_data[7:4];
      end
    end
  end

  assign busy = (state != IDLE) || (|dirty);

endmodule
